// File: rtl/dmem_initiator.sv
// dmem_initiator: serialises CPU loads/stores into little-endian byte beats.
// Define DMEM_TIMEOUT_EN to abort a beat not acked within TIMEOUT_CYC cycles.
module dmem_initiator #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic [1:0]        cpu_size_i,
    input  logic              cpu_signed_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              cpu_done_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        k_q;
    logic [1:0]        k_d;
    logic [1:0]        last_q;
    logic [1:0]        nlast;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q;
    logic [31:0]       rbuf_d;
    logic [31:0]       rdata_q;
    logic [31:0]       ext;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              we_q;
    logic              err_q;
    logic              err_d;
    logic              req;
    logic              bad;
    logic              misal;
    logic              busy;
    logic              ack_ok;
    logic              fin;
    logic              timeout;

    assign req    = cpu_read_i ^ cpu_write_i;
    assign busy   = state_q == BUSY;
    assign ack_ok = busy & mem_ack_i;
    assign fin    = ack_ok & (k_q == last_q);

    always_comb begin
        nlast = 2'd3;
        misal = cpu_addr_i[1:0] != 2'b00;
        unique case (1'b1)
            cpu_size_i == 2'b00: begin
                nlast = 2'd0;
                misal = 1'b0;
            end
            cpu_size_i == 2'b01: begin
                nlast = 2'd1;
                misal = cpu_addr_i[0];
            end
            default: ;
        endcase
    end

    assign bad = (cpu_read_i & cpu_write_i) | (req & misal);

    // Insert the returning byte so the final beat can be extended directly.
    always_comb begin
        rbuf_d = rbuf_q;
        rbuf_d[{k_q, 3'b000} +: 8] = mem_rdata_i;
    end

    always_comb begin
        ext = rbuf_d;
        unique case (1'b1)
            size_q == 2'b00:
                ext = {{24{signed_q & rbuf_d[7]}}, rbuf_d[7:0]};
            size_q == 2'b01:
                ext = {{16{signed_q & rbuf_d[15]}}, rbuf_d[15:0]};
            default: ;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_q;

    assign timeout = busy && !mem_ack_i &&
                     (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_q <= '0;
        end else if (!busy || mem_ack_i) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = TIMEOUT_CYC != 0;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bad) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (req) begin
                    state_d = BUSY;
                    k_d     = 2'd0;
                    err_d   = 1'b0;
                end
            end
            BUSY: begin
                if (ack_ok) begin
                    if (fin) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            last_q   <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            err_q   <= err_d;
            if (state_q == IDLE && req && !bad) begin
                base_q   <= cpu_addr_i;
                wdata_q  <= cpu_wdata_i;
                size_q   <= cpu_size_i;
                signed_q <= cpu_signed_i;
                we_q     <= cpu_write_i;
                last_q   <= nlast;
                rbuf_q   <= '0;
            end
            if (ack_ok && !we_q) begin
                rbuf_q <= rbuf_d;
            end
            if (fin && !we_q) begin
                rdata_q <= ext;
            end
        end
    end

    assign mem_req_o   = busy;
    assign mem_we_o    = busy & we_q;
    assign mem_addr_o  = busy ? base_q + ADDR_W'(k_q) : '0;
    assign mem_wdata_o = busy ? wdata_q[{k_q, 3'b000} +: 8] : '0;

    assign cpu_stall_o = busy |
                         ((state_q == IDLE) & (cpu_read_i | cpu_write_i));
    assign cpu_done_o  = state_q == DONE;
    assign err_o       = (state_q == DONE) & err_q;
    assign cpu_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// tb_dmem_initiator: randomized scoreboard bench for dmem_initiator.
// A byte-array memory answers beats with programmable ack delays.
module tb_dmem_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [7:0]  mwdata;
    logic [7:0]  mrdata;
    logic        mack;

    always #5 clk = ~clk;

    dmem_initiator #(
        .ADDR_W(32),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .cpu_read_i(rd),
        .cpu_write_i(wr),
        .cpu_addr_i(addr),
        .cpu_wdata_i(wdata),
        .cpu_size_i(size),
        .cpu_signed_i(sgn),
        .cpu_rdata_o(rdata),
        .cpu_stall_o(stall),
        .cpu_done_o(done),
        .err_o(err),
        .mem_req_o(mreq),
        .mem_we_o(mwe),
        .mem_addr_o(maddr),
        .mem_wdata_o(mwdata),
        .mem_rdata_i(mrdata),
        .mem_ack_i(mack)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } beat_t;

    exp_t        exp_q[$];
    beat_t       beat_q[$];
    logic [7:0]  ref_mem[256];
    logic [7:0]  phys_mem[256];
    logic [31:0] last_rdata = '0;
    int          n_total = 0;
    int          n_bad = 0;
    bit          active = 0;
    bit          chk_stall = 0;
    bit          req_seen = 0;
    int          delay_mode = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: reset quiescence, stall, and scoreboard pop on done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_rdata", rdata, 32'd0);
            check("rst_ctl", {27'd0, stall, done, err, mreq, mwe}, 32'd0);
            check("rst_maddr", maddr, 32'd0);
            check("rst_mwdata", {24'd0, mwdata}, 32'd0);
        end else begin
            if (mreq) req_seen = 1;
            if (done) begin
                check("done_stall", {31'd0, stall}, 32'd0);
                if (exp_q.size() == 0) begin
                    fail("spurious_done");
                end else begin
                    e = exp_q.pop_front();
                    check("err", {31'd0, err}, {31'd0, e.err});
                    check("rdata", rdata, e.rdata);
                end
            end else begin
                if (err) fail("err_without_done");
                if (active && chk_stall)
                    check("stall", {31'd0, stall}, 32'd1);
            end
        end
    end

    // Memory responder: checks each beat and acks after a delay.
    initial begin
        int    waited;
        int    d;
        bit    in_beat;
        beat_t cur;
        beat_t b;
        mack    = 1'b0;
        mrdata  = 8'h00;
        in_beat = 0;
        waited  = 0;
        d       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mack    = 1'b0;
                in_beat = 0;
                continue;
            end
            if (mack) begin
                mack    = 1'b0;
                in_beat = 0;
            end
            if (!mreq) begin
                in_beat = 0;
                continue;
            end
            if (!in_beat) begin
                in_beat   = 1;
                waited    = 0;
                if (delay_mode == -1) d = $urandom_range(3, 0);
                else if (delay_mode == -2) d = 1 << 30;
                else d = delay_mode;
                cur.addr  = maddr;
                cur.we    = mwe;
                cur.wdata = mwdata;
                if (beat_q.size() == 0) begin
                    fail("unexpected_beat");
                end else begin
                    b = beat_q.pop_front();
                    check("beat_addr", maddr, b.addr);
                    check("beat_we", {31'd0, mwe}, {31'd0, b.we});
                    if (b.we)
                        check("beat_wdata", {24'd0, mwdata}, {24'd0, b.wdata});
                end
            end else begin
                check("hold_addr", maddr, cur.addr);
                check("hold_we", {31'd0, mwe}, {31'd0, cur.we});
                check("hold_wdata", {24'd0, mwdata}, {24'd0, cur.wdata});
            end
            if (waited >= d) begin
                mack   = 1'b1;
                mrdata = phys_mem[maddr[7:0]];
                if (mwe) phys_mem[maddr[7:0]] = mwdata;
            end else begin
                waited++;
            end
        end
    end

    // Reference model: whole-transaction semantics, beats derived arithmetically.
    task automatic issue(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz,
                         input bit s, input int exp_lat);
        int         n;
        bit         isbad;
        exp_t       e;
        beat_t      b;
        longint     v;
        int         lat;
        logic [7:0] ix;
        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        isbad = (r && w) || (sz == 2'd1 && a[0]) ||
                (sz[1] && a[1:0] != 2'b00);
        e.err   = isbad;
        e.rdata = last_rdata;
        if (!isbad) begin
            v = 0;
            for (int i = 0; i < n; i++) begin
                ix      = a[7:0] + 8'(i);
                b.addr  = a + 32'(i);
                b.we    = w;
                b.wdata = wd[8*i +: 8];
                beat_q.push_back(b);
                if (w) ref_mem[ix] = b.wdata;
                else v += longint'(ref_mem[ix]) << (8 * i);
            end
            if (r) begin
                if (s && n < 4 && v[8*n-1]) v -= longint'(1) << (8 * n);
                e.rdata    = v[31:0];
                last_rdata = e.rdata;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rd        = r;
        wr        = w;
        addr      = a;
        wdata     = wd;
        size      = sz;
        sgn       = s;
        chk_stall = !(r && w);
        active    = 1;
        lat       = 1;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 400);
        rd     = 1'b0;
        wr     = 1'b0;
        active = 0;
        if (!done) fail("done_timeout");
        else if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic enter_reset();
        rst_n  = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        active = 0;
        exp_q.delete();
        beat_q.delete();
        last_rdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = phys_mem[i];
    endtask

    task automatic leave_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        beat_t       b;
        exp_t        e;
        int          lat;
        logic [31:0] a;
        logic [1:0]  sz;
        int          op;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        size  = '0;
        sgn   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            phys_mem[i] = 8'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        phys_mem[2] = 8'h34;
        phys_mem[3] = 8'h85;
        ref_mem[2]  = 8'h34;
        ref_mem[3]  = 8'h85;
        #1;
        rst_n = 1'b0;
        leave_reset();

        delay_mode = 0;
        issue(0, 1, 32'h8, 32'hDEADBEEF, 2'b10, 0, 6);
        check("word_store_mem", {phys_mem[11], phys_mem[10],
              phys_mem[9], phys_mem[8]}, 32'hDEADBEEF);
        issue(1, 0, 32'h2, 32'h0, 2'b01, 1, 4);
        check("half_signed", rdata, 32'hFFFF8534);
        issue(1, 0, 32'h2, 32'h0, 2'b01, 0, 4);
        check("half_unsigned", rdata, 32'h00008534);
        issue(1, 0, 32'h8, 32'h0, 2'b10, 0, 6);
        check("word_load", rdata, 32'hDEADBEEF);

        delay_mode = 3;
        issue(1, 0, 32'h4, 32'h0, 2'b10, 0, 0);
        issue(1, 0, 32'h9, 32'h0, 2'b00, 1, 0);

        delay_mode = 0;
        req_seen   = 0;
        issue(1, 0, 32'h6, 32'h0, 2'b10, 0, 2);
        issue(1, 1, 32'h0, 32'h1234, 2'b10, 0, 2);
        issue(1, 0, 32'h3, 32'h0, 2'b01, 1, 2);
        check("no_req_on_err", {31'd0, req_seen}, 32'd0);

        // Reset during the second beat of a word store.
        for (int i = 0; i < 4; i++) begin
            b.addr  = 32'h20 + 32'(i);
            b.we    = 1'b1;
            b.wdata = 8'(32'hCAFEF00D >> (8 * i));
            beat_q.push_back(b);
        end
        @(posedge clk);
        #1;
        rd        = 1'b0;
        wr        = 1'b1;
        addr      = 32'h20;
        wdata     = 32'hCAFEF00D;
        size      = 2'b10;
        chk_stall = 1;
        active    = 1;
        lat       = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(mreq && maddr == 32'h21) && lat < 20);
        if (lat >= 20) fail("beat2_not_seen");
        #2;
        enter_reset();
        #1;
        check("rst_req_now", {31'd0, mreq}, 32'd0);
        check("rst_stall_now", {31'd0, stall}, 32'd0);
        leave_reset();
        repeat (3) @(posedge clk);
        issue(1, 0, 32'h1, 32'h0, 2'b00, 0, 3);

        // Beat that is never acknowledged.
        delay_mode = -2;
        b.addr  = 32'h10;
        b.we    = 1'b0;
        b.wdata = 8'h00;
        beat_q.push_back(b);
        @(posedge clk);
        #1;
        rd        = 1'b1;
        wr        = 1'b0;
        addr      = 32'h10;
        size      = 2'b10;
        sgn       = 1'b0;
        chk_stall = 1;
        active    = 1;
`ifdef DMEM_TIMEOUT_EN
        e.err   = 1'b1;
        e.rdata = last_rdata;
        exp_q.push_back(e);
        lat = 1;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 100);
        rd     = 1'b0;
        active = 0;
        if (!done) fail("timeout_no_done");
        else check("timeout_lat", 32'(lat), 32'd18);
        beat_q.delete();
`else
        repeat (120) @(posedge clk);
        #1;
        check("hang_stall", {31'd0, stall}, 32'd1);
        check("hang_req", {31'd0, mreq}, 32'd1);
        @(negedge clk);
        #2;
        enter_reset();
        leave_reset();
`endif
        delay_mode = -1;
        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(9, 0);
            sz = 2'($urandom_range(3, 0));
            a  = $urandom;
            if ($urandom_range(7, 0) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz[1]) a[1:0] = 2'b00;
            end
            issue(op < 5 || op == 9, op >= 5, a, $urandom, sz,
                  1'($urandom_range(1, 0)), 0);
        end

        repeat (4) @(posedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("beat_q_empty", 32'(beat_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
